// File: rtl/move_packer.sv
// Packs a stream of 2-bit tile moves into one 17-bit move record.
// Layout: [16:14] read index (always 0 when presented), [13:0] seven 2-bit slots, slot 0 in [1:0].
module move_packer #(
  parameter int SLOTS   = 7,
  parameter int FIELD_W = 2,
  parameter int IDX_W   = 3,
  parameter int WORD_W  = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mv_valid,
  output logic              mv_ready,
  input  logic [1:0]        mv_dir,
  input  logic              flush,
  input  logic              clear,
  output logic              pk_valid,
  input  logic              pk_ready,
  output logic [WORD_W-1:0] pk_word,
  output logic [IDX_W-1:0]  pk_count
);

  // state | meaning
  // FILL  | accepting moves into the next free slot
  // HOLD  | record complete, waiting for the consumer handshake
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(SLOTS - 1);

  state_t                     state;
  logic [IDX_W-1:0]           cnt;
  logic [SLOTS*FIELD_W-1:0]   fields;
  logic                       accept;

  assign accept = mv_valid && (state == FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      cnt    <= '0;
      fields <= '0;
    end else if (clear) begin
      state  <= FILL;
      cnt    <= '0;
      fields <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int i = 0; i < SLOTS; i++) begin
              if (cnt == IDX_W'(i))
                fields[i*FIELD_W +: FIELD_W] <= mv_dir;
            end
            cnt <= cnt + 1'b1;
            // the move lands before the record closes, so flush+move includes it
            if (cnt == LAST || flush)
              state <= HOLD;
          end else if (flush && cnt != '0) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (pk_ready) begin
            state  <= FILL;
            cnt    <= '0;
            fields <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign mv_ready = (state == FILL);
  assign pk_valid = (state == HOLD);
  assign pk_word  = {{IDX_W{1'b0}}, fields};
  assign pk_count = cnt;

endmodule

// File: tb/tb_move_packer.sv
// Scoreboard bench for move_packer: a queue-based move model predicts each record,
// a negedge monitor compares whatever the packer presents.
module tb_move_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mv_valid = 1'b0;
  logic [1:0]  mv_dir = 2'b00;
  logic        flush = 1'b0;
  logic        clear = 1'b0;
  logic        pk_ready = 1'b0;
  logic        mv_ready;
  logic        pk_valid;
  logic [16:0] pk_word;
  logic [2:0]  pk_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  move_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mv_valid (mv_valid),
    .mv_ready (mv_ready),
    .mv_dir   (mv_dir),
    .flush    (flush),
    .clear    (clear),
    .pk_valid (pk_valid),
    .pk_ready (pk_ready),
    .pk_word  (pk_word),
    .pk_count (pk_count)
  );

  typedef struct {
    logic [16:0] w;
    logic [2:0]  n;
  } rec_t;

  rec_t       exp_q[$];
  logic [1:0] cur[$];
  bit         m_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Record value = sum of move_i * 4^i; count = number of moves collected.
  function automatic rec_t make_rec();
    rec_t r;
    int   acc = 0;
    for (int i = 0; i < cur.size(); i++)
      acc += int'(cur[i]) * (1 << (2 * i));
    r.w = 17'(acc);
    r.n = 3'(cur.size());
    return r;
  endfunction

  // Reference model: moves gathered in a queue, record emitted at 7 moves or on flush.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      cur.delete();
      exp_q.delete();
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (mv_valid)
        cur.push_back(mv_dir);
      if ((mv_valid && cur.size() == 7) || (flush && cur.size() > 0)) begin
        exp_q.push_back(make_rec());
        cur.delete();
        m_hold = 1'b1;
      end
    end else if (pk_ready) begin
      m_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mv_ready", 32'(mv_ready), 32'(!m_hold));
      chk("pk_valid", 32'(pk_valid), 32'(m_hold));
      if (pk_valid) begin
        if (exp_q.size() == 0) begin
          chk("record_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("pk_word", 32'(pk_word), 32'(exp_q[0].w));
          chk("pk_count", 32'(pk_count), 32'(exp_q[0].n));
          if (pk_ready && !clear)
            void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit v, input logic [1:0] d, input bit f, input bit c, input bit r);
    mv_valid = v;
    mv_dir   = d;
    flush    = f;
    clear    = c;
    pk_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pk_word", 32'(pk_word), 32'd0);
    chk("rst_pk_count", 32'(pk_count), 32'd0);
    chk("rst_mv_ready", 32'(mv_ready), 32'd1);
    chk("rst_pk_valid", 32'(pk_valid), 32'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #12;
    #1;
    async_reset();
    @(posedge clk);
    #1;

    // seven back-to-back moves
    step(1, 2'd0, 0, 0, 0);
    step(1, 2'd1, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd0, 0, 0, 0);
    step(1, 2'd1, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    chk("t2_word", 32'(pk_word), 32'(17'b000_10_01_00_11_10_01_00));
    chk("t2_count", 32'(pk_count), 32'd7);
    chk("t2_mv_ready", 32'(mv_ready), 32'd0);

    // stall in HOLD with moves and flush driven
    for (int i = 0; i < 5; i++)
      step(1, 2'(i), 1, 0, 0);
    chk("t3_word_stable", 32'(pk_word), 32'(17'b000_10_01_00_11_10_01_00));
    step(0, 2'd0, 0, 0, 1);
    chk("t3_pk_valid", 32'(pk_valid), 32'd0);
    chk("t3_mv_ready", 32'(mv_ready), 32'd1);

    // partial record closed by a lone flush
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    step(0, 2'd0, 1, 0, 0);
    chk("t4_word", 32'(pk_word), 32'(17'b000_00_00_00_00_10_11_11));
    chk("t4_count", 32'(pk_count), 32'd3);
    step(0, 2'd0, 0, 0, 1);

    // empty flush ignored, then move+flush together
    step(0, 2'd0, 1, 0, 0);
    chk("t5_empty_flush", 32'(pk_valid), 32'd0);
    step(1, 2'd1, 0, 0, 0);
    step(1, 2'd3, 1, 0, 0);
    chk("t5_count", 32'(pk_count), 32'd2);
    chk("t5_low", 32'(pk_word[3:0]), 32'(4'b1101));
    step(0, 2'd0, 0, 0, 1);

    // clear drops a partial record and a coincident move
    for (int i = 0; i < 4; i++)
      step(1, 2'(i + 1), 0, 0, 0);
    step(1, 2'd2, 0, 1, 0);
    chk("t6_word", 32'(pk_word), 32'd0);
    chk("t6_count", 32'(pk_count), 32'd0);
    for (int i = 0; i < 7; i++)
      step(1, 2'($urandom_range(0, 3)), 0, 0, 0);
    step(0, 2'd0, 0, 0, 1);
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1);
      if (i == 1500)
        async_reset();
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
